// File: rtl/piso_pkg.sv
// Shared state encoding and sizing helper for the parallel-in/serial-out serializer.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } pisoState_t;

  // Counter must hold WIDTH itself, so size it for WIDTH+1 values.
  function automatic int cntW(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Serialises a WIDTH-bit parallel word one bit per clock, with a ready/load handshake
// that supports gapless back-to-back words, an end-of-word pulse and a sticky overrun flag.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] dIn,
  output logic             ready,
  output logic             sOut,
  output logic             sValid,
  output logic             done,
  output logic             overrun
);

  localparam int CNT_W = cntW(WIDTH);

  pisoState_t       state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             lastBit;
  logic             headBit;

  assign lastBit = (state == ST_SHIFT) && (cnt == CNT_W'(1));
  assign ready   = (state == ST_IDLE) || lastBit;
  assign sValid  = (state == ST_SHIFT);
  assign headBit = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
  assign sOut    = sValid & headBit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load && !ready)
        overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (load) begin
            shreg <= dIn;
            cnt   <= CNT_W'(WIDTH);
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // done fires on retiring the last bit even if a new word starts on the same edge
          if (lastBit)
            done <= 1'b1;
          if (lastBit && load) begin
            shreg <= dIn;
            cnt   <= CNT_W'(WIDTH);
          end else begin
            if (MSB_FIRST != 0)
              shreg <= {shreg[WIDTH-2:0], 1'b0};
            else
              shreg <= {1'b0, shreg[WIDTH-1:1]};
            cnt <= cnt - CNT_W'(1);
            if (lastBit)
              state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: upstream PIPO register feeds an MSB-first and an LSB-first serializer;
// expected bits are queued when a word is accepted and popped as sValid bits appear.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       loadA, loadB;
  logic       pipoLd;
  logic [3:0] pipoD, pipoQ;
  logic       readyA, sOutA, sValidA, doneA, overrunA;
  logic       readyB, sOutB, sValidB, doneB, overrunB;

  int passCnt  = 0;
  int totalCnt = 0;
  int doneCntA = 0;
  int doneCntB = 0;
  logic qA[$];
  logic qB[$];

  always #100 clk = ~clk;

  // Upstream 4-bit parallel-load holding register
  always_ff @(posedge clk) begin
    if (rst)         pipoQ <= '0;
    else if (pipoLd) pipoQ <= pipoD;
  end

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1)) dutA (
    .clk(clk), .rst(rst), .load(loadA), .dIn(pipoQ),
    .ready(readyA), .sOut(sOutA), .sValid(sValidA), .done(doneA), .overrun(overrunA)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(0)) dutB (
    .clk(clk), .rst(rst), .load(loadB), .dIn(pipoQ),
    .ready(readyB), .sOut(sOutB), .sValid(sValidB), .done(doneB), .overrun(overrunB)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #10;
  endtask

  task automatic pipoLoad(input logic [3:0] w);
    pipoD  = w;
    pipoLd = 1'b1;
    cyc();
    pipoLd = 1'b0;
  endtask

  task automatic pushA(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) qA.push_back(w[i]);
  endtask

  task automatic pushB(input logic [3:0] w);
    for (int i = 0; i < 4; i++) qB.push_back(w[i]);
  endtask

  // Scoreboard: every valid bit must match the next queued bit; idle sOut must be 0
  always @(negedge clk) begin
    if (sValidA) begin
      if (qA.size() == 0) check("A_extra_bit", 32'(sValidA), 32'd0);
      else                check("A_bit", 32'(sOutA), 32'(qA.pop_front()));
    end else if (sOutA !== 1'b0) begin
      check("A_idle_sOut", 32'(sOutA), 32'd0);
    end
    if (sValidB) begin
      if (qB.size() == 0) check("B_extra_bit", 32'(sValidB), 32'd0);
      else                check("B_bit", 32'(sOutB), 32'(qB.pop_front()));
    end
    if (doneA === 1'b1) doneCntA++;
    if (doneB === 1'b1) doneCntB++;
  end

  initial begin
    logic [3:0] vals [3];
    vals = '{4'd15, 4'd10, 4'd5};
    rst = 1'b1; loadA = 1'b0; loadB = 1'b0; pipoLd = 1'b0; pipoD = '0;
    cyc(); cyc();
    check("rst_readyA", 32'(readyA), 32'd1);
    check("rst_sValidA", 32'(sValidA), 32'd0);
    check("rst_sOutA", 32'(sOutA), 32'd0);
    check("rst_doneA", 32'(doneA), 32'd0);
    check("rst_overrunA", 32'(overrunA), 32'd0);
    check("rst_readyB", 32'(readyB), 32'd1);
    rst = 1'b0;
    cyc();

    // 1: single word 0xA, MSB first
    pipoLoad(4'hA);
    loadA = 1'b1; pushA(4'hA);
    cyc(); loadA = 1'b0;
    check("t1_busy_ready", 32'(readyA), 32'd0);
    check("t1_sValid0", 32'(sValidA), 32'd1);
    cyc(); cyc();
    check("t1_ready_b2", 32'(readyA), 32'd0);
    cyc();
    check("t1_last_ready", 32'(readyA), 32'd1);
    check("t1_last_done", 32'(doneA), 32'd0);
    cyc();
    check("t1_done", 32'(doneA), 32'd1);
    check("t1_idle_sValid", 32'(sValidA), 32'd0);
    check("t1_idle_ready", 32'(readyA), 32'd1);
    cyc();
    check("t1_done_once", 32'(doneA), 32'd0);
    check("t1_doneCnt", 32'(doneCntA), 32'd1);

    // 2: LSB-first instance, 0xD -> 1,0,1,1
    pipoLoad(4'hD);
    loadB = 1'b1; pushB(4'hD);
    cyc(); loadB = 1'b0;
    repeat (4) cyc();
    check("t2_done", 32'(doneB), 32'd1);
    cyc();
    check("t2_doneCnt", 32'(doneCntB), 32'd1);
    check("t2_overrun", 32'(overrunB), 32'd0);
    check("t2_qB_empty", 32'(qB.size()), 32'd0);

    // 3: back-to-back 0xF then 0x3 loaded in the last-bit cycle
    pipoLoad(4'hF);
    loadA = 1'b1; pushA(4'hF);
    cyc(); loadA = 1'b0;
    pipoD = 4'h3; pipoLd = 1'b1;
    cyc(); pipoLd = 1'b0;
    check("t3_sValid_b1", 32'(sValidA), 32'd1);
    cyc();
    check("t3_sValid_b2", 32'(sValidA), 32'd1);
    cyc();
    check("t3_last_ready", 32'(readyA), 32'd1);
    loadA = 1'b1; pushA(4'h3);
    cyc(); loadA = 1'b0;
    check("t3_w2_done", 32'(doneA), 32'd1);
    check("t3_w2_sValid", 32'(sValidA), 32'd1);
    cyc();
    check("t3_w2_nodone", 32'(doneA), 32'd0);
    cyc(); cyc();
    check("t3_w2_b3_sValid", 32'(sValidA), 32'd1);
    cyc();
    check("t3_final_done", 32'(doneA), 32'd1);
    check("t3_final_sValid", 32'(sValidA), 32'd0);
    cyc();
    check("t3_doneCnt", 32'(doneCntA), 32'd3);
    check("t3_overrun", 32'(overrunA), 32'd0);

    // 4: overrun during 2nd bit of 0x9; stream unaffected, flag sticky
    pipoLoad(4'h9);
    loadA = 1'b1; pushA(4'h9);
    cyc(); loadA = 1'b0;
    pipoD = 4'h6; pipoLd = 1'b1;
    cyc(); pipoLd = 1'b0;
    loadA = 1'b1;
    check("t4_busy_ready", 32'(readyA), 32'd0);
    cyc(); loadA = 1'b0;
    check("t4_overrun", 32'(overrunA), 32'd1);
    cyc(); cyc();
    check("t4_done", 32'(doneA), 32'd1);
    check("t4_idle", 32'(sValidA), 32'd0);
    cyc();
    pipoLoad(4'h5);
    loadA = 1'b1; pushA(4'h5);
    cyc(); loadA = 1'b0;
    repeat (5) cyc();
    check("t4_overrun_sticky", 32'(overrunA), 32'd1);
    check("t4_doneCnt", 32'(doneCntA), 32'd5);

    // 5: reset after 2 bits of 0xC abandons the word
    pipoLoad(4'hC);
    loadA = 1'b1; pushA(4'hC);
    cyc(); loadA = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    qA.delete();
    check("t5_sValid", 32'(sValidA), 32'd0);
    check("t5_sOut", 32'(sOutA), 32'd0);
    check("t5_ready", 32'(readyA), 32'd1);
    check("t5_overrun", 32'(overrunA), 32'd0);
    check("t5_done", 32'(doneA), 32'd0);
    cyc(); cyc();
    check("t5_nodone", 32'(doneCntA), 32'd5);
    pipoLoad(4'h5);
    loadA = 1'b1; pushA(4'h5);
    cyc(); loadA = 1'b0;
    repeat (5) cyc();
    check("t5_doneCnt", 32'(doneCntA), 32'd6);

    // 6: dIn toggles with load low
    for (int i = 0; i < 6; i++) begin
      pipoD = vals[i % 3]; pipoLd = 1'b1;
      cyc();
      check("t6_sValid", 32'(sValidA), 32'd0);
      check("t6_sOut", 32'(sOutA), 32'd0);
      check("t6_done", 32'(doneA), 32'd0);
    end
    pipoLd = 1'b0;
    cyc();
    check("end_qA_empty", 32'(qA.size()), 32'd0);
    check("end_qB_empty", 32'(qB.size()), 32'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
